// File: rtl/btn_debounce_scheduler_if.sv
// Signal bundle between the button pins / UART control side and the shared-timer debouncer.
// The master drives raw button levels and the slave returns the debounced view.
interface btn_debounce_scheduler_if #(
    parameter int NUM_BTN = 4
);
    localparam int IDX_W = $clog2(NUM_BTN);

    logic [NUM_BTN-1:0] btn;
    logic [NUM_BTN-1:0] db_level;
    logic [NUM_BTN-1:0] db_tick;
    logic               busy;
    logic [IDX_W-1:0]   grant_idx;

    modport master (
        output btn,
        input  db_level,
        input  db_tick,
        input  busy,
        input  grant_idx
    );

    modport slave (
        input  btn,
        output db_level,
        output db_tick,
        output busy,
        output grant_idx
    );
endinterface

// File: rtl/btn_debounce_scheduler.sv
// Debounces NUM_BTN raw inputs with a single shared settle timer that a round-robin
// scheduler lends to whichever input's synchronized level disagrees with its debounced level.
module btn_debounce_scheduler #(
    parameter int NUM_BTN = 4,
    parameter int N       = 22
) (
    input  logic                     clk,
    input  logic                     reset,
    btn_debounce_scheduler_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_BTN);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_TIMING = 1'b1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BTN - 1);

    logic [NUM_BTN-1:0] r_sync1;
    logic [NUM_BTN-1:0] r_sync2;
    logic [NUM_BTN-1:0] r_db_level;
    logic [NUM_BTN-1:0] r_db_tick;
    logic [0:0]         r_state;
    logic [N-1:0]       r_count;
    logic [IDX_W-1:0]   r_cur;
    logic [IDX_W-1:0]   r_rr_ptr;

    logic [NUM_BTN-1:0] w_req;
    logic               w_any_req;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W-1:0]   w_rr_next;
    logic               w_cur_req;
    logic               w_last_tick;

    // A request is a level mismatch, so a waiting input can never lose its turn.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_req
            assign w_req[gi] = r_sync2[gi] ^ r_db_level[gi];
        end
    endgenerate

    assign w_any_req = |w_req;

    // First requester at or after rr_ptr, wrapping without assuming a power-of-2 count.
    always_comb begin
        int  cand;
        logic found;
        cand   = 0;
        found  = 1'b0;
        w_pick = '0;
        for (int k = 0; k < NUM_BTN; k++) begin
            cand = int'(r_rr_ptr) + k;
            if (cand >= NUM_BTN) begin
                cand = cand - NUM_BTN;
            end
            if (!found && w_req[cand]) begin
                found  = 1'b1;
                w_pick = IDX_W'(cand);
            end
        end
    end

    assign w_rr_next   = (w_pick == LAST_IDX) ? '0 : (w_pick + 1'b1);
    assign w_cur_req   = w_req[r_cur];
    assign w_last_tick = (r_count == N'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_db_level <= '0;
            r_db_tick  <= '0;
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_cur      <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_sync1   <= bus.btn;
            r_sync2   <= r_sync1;
            r_db_tick <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_cur    <= w_pick;
                        r_rr_ptr <= w_rr_next;
                        r_count  <= '1;
                        r_state  <= S_TIMING;
                    end
                end
                S_TIMING: begin
                    if (w_cur_req) begin
                        r_count <= r_count - 1'b1;
                        if (w_last_tick) begin
                            r_db_level[r_cur] <= r_sync2[r_cur];
                            r_db_tick[r_cur]  <= r_sync2[r_cur];
                            r_state           <= S_IDLE;
                        end
                    end else begin
                        // Input bounced back before settling: drop the grant, keep the count.
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.db_level  = r_db_level;
    assign bus.db_tick   = r_db_tick;
    assign bus.busy      = (r_state == S_TIMING);
    assign bus.grant_idx = r_cur;
endmodule

// File: tb/tb_btn_debounce_scheduler.sv
// Directed bench: a four-input instance driven from a vector table plus hand-written
// multi-cycle sequences, and a three-input instance checking the non-power-of-2 wrap.
module tb_btn_debounce_scheduler;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    btn_debounce_scheduler_if #(.NUM_BTN(4)) bus4 ();
    btn_debounce_scheduler_if #(.NUM_BTN(3)) bus3 ();

    btn_debounce_scheduler #(.NUM_BTN(4), .N(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    btn_debounce_scheduler #(.NUM_BTN(3), .N(4)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] btn;
        int         wait_n;
        logic [3:0] lvl;
        logic [3:0] tick;
        logic       busy;
        logic [1:0] grant;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] b, input int w, input logic [3:0] l,
                       input logic [3:0] t, input logic bz, input logic [1:0] g);
        vec_t v;
        v.btn = b; v.wait_n = w; v.lvl = l; v.tick = t; v.busy = bz; v.grant = g;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string name, input logic [3:0] l, input logic [3:0] t,
                          input logic bz, input logic [1:0] g);
        check({name, ".level"}, int'(bus4.db_level), int'(l));
        check({name, ".tick"},  int'(bus4.db_tick),  int'(t));
        check({name, ".busy"},  int'(bus4.busy),     int'(bz));
        check({name, ".grant"}, int'(bus4.grant_idx), int'(g));
    endtask

    initial begin
        int ticks;
        int bad_idx;
        int ngr;
        int grants[8];
        logic prev_busy;
        logic [3:0] exp_t;

        total = 0;
        bad = 0;
        reset = 1'b0;
        bus4.btn = 4'b0000;
        bus3.btn = 3'b000;

        // Clean press/release on input 1, bounce abort on input 0, then fairness 2 -> 3 -> 0.
        add(4'b0000,  2, 4'b0000, 4'b0000, 1'b0, 2'd0);
        add(4'b0010,  3, 4'b0000, 4'b0000, 1'b1, 2'd1);
        add(4'b0010, 14, 4'b0000, 4'b0000, 1'b1, 2'd1);
        add(4'b0010,  1, 4'b0010, 4'b0010, 1'b0, 2'd1);
        add(4'b0010,  1, 4'b0010, 4'b0000, 1'b0, 2'd1);
        add(4'b0000,  3, 4'b0010, 4'b0000, 1'b1, 2'd1);
        add(4'b0000, 15, 4'b0000, 4'b0000, 1'b0, 2'd1);
        add(4'b0000,  3, 4'b0000, 4'b0000, 1'b0, 2'd1);
        add(4'b0001,  3, 4'b0000, 4'b0000, 1'b1, 2'd0);
        add(4'b0001,  3, 4'b0000, 4'b0000, 1'b1, 2'd0);
        add(4'b0000,  3, 4'b0000, 4'b0000, 1'b0, 2'd0);
        add(4'b0000,  2, 4'b0000, 4'b0000, 1'b0, 2'd0);
        add(4'b0001,  3, 4'b0000, 4'b0000, 1'b1, 2'd0);
        add(4'b0001, 14, 4'b0000, 4'b0000, 1'b1, 2'd0);
        add(4'b0001,  1, 4'b0001, 4'b0001, 1'b0, 2'd0);
        add(4'b0001,  1, 4'b0001, 4'b0000, 1'b0, 2'd0);
        add(4'b0101,  3, 4'b0001, 4'b0000, 1'b1, 2'd2);
        add(4'b1100, 15, 4'b0101, 4'b0100, 1'b0, 2'd2);
        add(4'b1100,  1, 4'b0101, 4'b0000, 1'b1, 2'd3);
        add(4'b1100, 15, 4'b1101, 4'b1000, 1'b0, 2'd3);
        add(4'b1100,  1, 4'b1101, 4'b0000, 1'b1, 2'd0);
        add(4'b1100, 15, 4'b1100, 4'b0000, 1'b0, 2'd0);
        add(4'b1100,  2, 4'b1100, 4'b0000, 1'b0, 2'd0);

        step();
        step();
        check4("reset_state", 4'b0000, 4'b0000, 1'b0, 2'd0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus4.btn = vecs[i].btn;
            for (int c = 0; c < vecs[i].wait_n; c++) step();
            check4($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].tick, vecs[i].busy, vecs[i].grant);
            $display("vec %0d: btn=%b wait=%0d level=%b tick=%b busy=%0d grant=%0d",
                     i, vecs[i].btn, vecs[i].wait_n, bus4.db_level, bus4.db_tick,
                     bus4.busy, bus4.grant_idx);
        end

        // All four inputs high out of reset: commits 0,1,2,3 sixteen cycles apart.
        reset = 1'b0;
        bus4.btn = 4'b1111;
        step();
        reset = 1'b1;
        ticks = 0;
        for (int c = 1; c <= 70; c++) begin
            step();
            exp_t = 4'b0000;
            for (int k = 0; k < 4; k++) if (c == 18 + 16 * k) exp_t[k] = 1'b1;
            check($sformatf("simul_tick_c%0d", c), int'(bus4.db_tick), int'(exp_t));
            ticks += $countones(bus4.db_tick);
        end
        check("simul_tick_count", ticks, 4);
        check("simul_level", int'(bus4.db_level), 4'b1111);
        $display("simultaneous: ticks=%0d level=%b", ticks, bus4.db_level);

        // Release input 3 only; reset lands while its timer holds 7.
        bus4.btn = 4'b0111;
        for (int c = 0; c < 11; c++) step();
        check("pre_reset_busy", int'(bus4.busy), 1);
        check("pre_reset_grant", int'(bus4.grant_idx), 3);
        reset = 1'b0;
        #2;
        check4("async_reset", 4'b0000, 4'b0000, 1'b0, 2'd0);
        $display("async reset: level=%b busy=%0d grant=%0d",
                 bus4.db_level, bus4.busy, bus4.grant_idx);
        bus4.btn = 4'b0100;
        step();
        step();
        reset = 1'b1;
        ticks = 0;
        for (int c = 1; c <= 25; c++) begin
            step();
            exp_t = (c == 18) ? 4'b0100 : 4'b0000;
            check($sformatf("post_reset_tick_c%0d", c), int'(bus4.db_tick), int'(exp_t));
            ticks += $countones(bus4.db_tick);
        end
        check("post_reset_tick_count", ticks, 1);
        $display("post reset: ticks=%0d level=%b", ticks, bus4.db_level);

        // Three-input instance: grants must run 0,1,2 and wrap back to 0.
        bus3.btn = 3'b111;
        ngr = 0;
        bad_idx = 0;
        prev_busy = 1'b0;
        for (int c = 1; c <= 130; c++) begin
            if (c == 61) bus3.btn = 3'b000;
            step();
            if (bus3.grant_idx == 2'd3) bad_idx++;
            if (bus3.busy && !prev_busy && ngr < 8) begin
                grants[ngr] = int'(bus3.grant_idx);
                ngr++;
            end
            prev_busy = bus3.busy;
        end
        check("wrap_grant_count", ngr, 6);
        check("wrap_idx3_seen", bad_idx, 0);
        for (int k = 0; k < 6; k++) begin
            if (k < ngr) check($sformatf("wrap_grant%0d", k), grants[k], k % 3);
            else         check($sformatf("wrap_grant%0d", k), -1, k % 3);
        end
        check("wrap_level", int'(bus3.db_level), 0);
        $display("wrap: grants=%0d idx3_cycles=%0d", ngr, bad_idx);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
